// File: rtl/aes_decrypt_wrapper_top.sv
// rtl/aes_decrypt_wrapper_top.sv - AES-128 receive wrapper: serial ciphertext in, decrypt core handshake, serial plaintext out
// Optional decrypt watchdog enabled by defining AES_DEC_TIMEOUT_EN.
module aes_decrypt_wrapper_top #(
    parameter logic [127:0] KEY            = 128'h100F0E0D0C0B0A090807060504030201,
    parameter logic [127:0] EXP_PLAIN      = 128'h00112233445566778899AABBCCDDEEFF,
    parameter int           TIMEOUT_CYCLES = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ser_in,
    input  logic         ser_in_valid,
    output logic         ser_out,
    output logic         ser_out_valid,
    output logic         busy,
    output logic         dec_start,
    output logic [127:0] dec_cipher,
    output logic [127:0] dec_key,
    input  logic [127:0] dec_plain,
    input  logic         dec_done,
    output logic [15:0]  led
);

    typedef enum logic [1:0] {S_RX, S_START, S_WAIT, S_TX} state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [6:0]   r_cnt;
    logic [127:0] r_cipher;
    logic [127:0] r_plain;
    logic         r_dec_start;
    logic [2:0]   r_led_match;
    logic         r_led_hi;
    logic         r_ovr;
    logic         w_rx_fire;
    logic         w_capture;
    logic         w_timeout;
    logic         w_to_led;

    assign w_rx_fire = (r_state == S_RX) && ser_in_valid;
    assign w_capture = (r_state == S_WAIT) && dec_done;

`ifdef AES_DEC_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TW-1:0] r_to_cnt;
    logic          r_to_flag;

    // A done arriving on the limit cycle takes priority over the timeout.
    assign w_timeout = (r_state == S_WAIT) && !dec_done && (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign w_to_led  = r_to_flag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt  <= '0;
            r_to_flag <= 1'b0;
        end else begin
            if (r_state == S_WAIT) begin
                r_to_cnt <= r_to_cnt + TW'(1);
            end else begin
                r_to_cnt <= '0;
            end
            if (w_timeout) begin
                r_to_flag <= 1'b1;
            end
        end
    end
`else
    assign w_timeout = 1'b0;
    assign w_to_led  = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RX:    if (w_rx_fire && (r_cnt == 7'd127)) w_state_nxt = S_START;
            S_START: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (w_capture) begin
                    w_state_nxt = S_TX;
                end else if (w_timeout) begin
                    w_state_nxt = S_RX;
                end
            end
            S_TX:    if (r_cnt == 7'd127) w_state_nxt = S_RX;
            default: w_state_nxt = S_RX;
        endcase
    end

    // r_cnt serves as the RX bit counter and then the TX bit index; it wraps to 0 at each handoff.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_RX;
            r_cnt       <= '0;
            r_cipher    <= '0;
            r_plain     <= '0;
            r_dec_start <= 1'b0;
            r_led_match <= '0;
            r_led_hi    <= 1'b0;
            r_ovr       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_dec_start <= (r_state == S_START);
            if (w_rx_fire) begin
                r_cipher <= {r_cipher[126:0], ser_in};
                r_cnt    <= r_cnt + 7'd1;
            end else if (r_state == S_TX) begin
                r_cnt <= r_cnt + 7'd1;
            end
            if (ser_in_valid && (r_state != S_RX)) begin
                r_ovr <= 1'b1;
            end
            if (w_capture) begin
                r_plain     <= dec_plain;
                r_led_match <= {dec_plain == EXP_PLAIN,
                                dec_plain[15:8] == EXP_PLAIN[15:8],
                                dec_plain[7:0] == EXP_PLAIN[7:0]};
                r_led_hi    <= (dec_plain[127:120] == EXP_PLAIN[127:120]);
            end
        end
    end

    // Bit 127-i of the plaintext equals index ~i for a 7-bit i.
    assign ser_out       = (r_state == S_TX) ? r_plain[~r_cnt] : 1'b0;
    assign ser_out_valid = (r_state == S_TX);
    assign busy          = (r_state != S_RX);
    assign dec_start     = r_dec_start;
    assign dec_cipher    = r_cipher;
    assign dec_key       = KEY;
    assign led           = {r_led_hi, w_to_led, r_ovr, 10'b0, r_led_match};

endmodule
